// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader_if
// Brief    : Instruction-word stream (valid/ready/last) feeding imem_loader.
//            The source drives the master modport, the loader the slave one.
// Revision : 1.0  initial release
// ============================================================================
interface imem_loader_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_last;
    logic                  in_ready;

    modport master (output in_valid, output in_data, output in_last, input  in_ready);
    modport slave  (input  in_valid, input  in_data, input  in_last, output in_ready);
endinterface
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Brief    : Boot-time program loader. Streams instruction words into
//            instruction memory from address 0, holds the processor in reset
//            while loading, releases it after the final write and re-asserts
//            reset once the PC reaches the programmed end address.
// Revision : 1.0  initial release
// ============================================================================
module imem_loader #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    input  wire logic                  start,
    imem_loader_if.slave               in_bus,
    output logic                       imem_we,
    output logic [ADDR_WIDTH-1:0]      imem_addr,
    output logic [DATA_WIDTH-1:0]      imem_wdata,
    output logic                       cpu_reset,
    input  wire logic [15:0]           pc,
    input  wire logic [15:0]           end_pc,
    output logic                       busy,
    output logic                       done,
    output logic                       error,
    output logic [ADDR_WIDTH:0]        word_count,
    output logic [15:0]                run_cycles
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_FLUSH  = 3'd2,
        ST_RUN    = 3'd3,
        ST_HALTED = 3'd4
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] c_ptr_last = '1;
    localparam logic [ADDR_WIDTH-1:0] c_ptr_one  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   c_cnt_one  = (ADDR_WIDTH+1)'(1);
    localparam logic [15:0]           c_run_max  = 16'hFFFF;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic                  r_first_run;   // masks the end_pc compare in the first RUN cycle

    logic                  w_accept;
    assign w_accept = in_bus.in_valid & in_bus.in_ready;

    // Loader FSM; every output is a register updated here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_ptr           <= '0;
            r_first_run     <= 1'b0;
            in_bus.in_ready <= 1'b0;
            imem_we         <= 1'b0;
            imem_addr       <= '0;
            imem_wdata      <= '0;
            cpu_reset       <= 1'b1;
            busy            <= 1'b0;
            done            <= 1'b0;
            error           <= 1'b0;
            word_count      <= '0;
            run_cycles      <= '0;
        end else begin
            // A write strobe lives for exactly the cycle after its accept.
            imem_we <= 1'b0;

            unique case (r_state)
                ST_IDLE, ST_HALTED: begin
                    if (start) begin
                        r_state         <= ST_LOAD;
                        r_ptr           <= '0;
                        word_count      <= '0;
                        error           <= 1'b0;
                        run_cycles      <= '0;
                        done            <= 1'b0;
                        busy            <= 1'b1;
                        in_bus.in_ready <= 1'b1;
                    end
                end

                ST_LOAD: begin
                    if (w_accept) begin
                        imem_we    <= 1'b1;
                        imem_addr  <= r_ptr;
                        imem_wdata <= in_bus.in_data;
                        r_ptr      <= r_ptr + c_ptr_one;
                        word_count <= word_count + c_cnt_one;
                        if (in_bus.in_last) begin
                            r_state         <= ST_FLUSH;
                            in_bus.in_ready <= 1'b0;
                        end else if (r_ptr == c_ptr_last) begin
                            // Memory is full without a terminating word: abort,
                            // keep the processor held.
                            r_state         <= ST_IDLE;
                            in_bus.in_ready <= 1'b0;
                            error           <= 1'b1;
                            busy            <= 1'b0;
                        end
                    end
                end

                ST_FLUSH: begin
                    // Final write lands at this edge; release the processor.
                    r_state     <= ST_RUN;
                    cpu_reset   <= 1'b0;
                    r_first_run <= 1'b1;
                end

                ST_RUN: begin
                    r_first_run <= 1'b0;
                    if (run_cycles != c_run_max) begin
                        run_cycles <= run_cycles + 16'd1;
                    end
                    if (!r_first_run && (pc == end_pc)) begin
                        r_state   <= ST_HALTED;
                        cpu_reset <= 1'b1;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
